// File: rtl/fetch_pkg.sv
// fetch_pkg: shared types and defaults for the fetch front end.
// Instruction/redirect bundles are consumed by fetch and decode alike.
package fetch_pkg;

  localparam logic [63:0] FE_RESET_PC        = 64'h0;
  localparam int          FE_BUF_DEPTH       = 4;
  localparam int          FE_MAX_OUTSTANDING = 4;

  typedef struct packed {
    logic [31:0] instr;
    logic [63:0] pc;
`ifdef SIMULATION
    logic [63:0] SIMID;
`endif
  } t_instr_pkt;

  typedef struct packed {
    logic        valid;
    logic [63:0] pc;
  } t_nuke_pkt;

endpackage

// File: rtl/fetch_if.sv
// fetch_if: imem request/response port plus the fe1 hand-off to decode.
// master = fetch unit, slave = memory/decode side.
interface fetch_if;
  import fetch_pkg::*;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [63:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        decode_ready_de0;
  logic        valid_fe1;
  t_instr_pkt  instr_fe1;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    output valid_fe1,
    output instr_fe1,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    input  decode_ready_de0
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    input  valid_fe1,
    input  instr_fe1,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    output decode_ready_de0
  );

endinterface

// File: rtl/fetch_gen_fifo.sv
// fetch_gen_fifo: single-push/single-pop circular FIFO with sync clear.
// Push and pop together on a full FIFO is allowed.
module fetch_gen_fifo #(
  parameter type T     = logic,
  parameter int  DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr_i,
  input  logic          push_i,
  input  T              data_i,
  input  logic          pop_i,
  output T              data_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  T              mem_q [DEPTH];
  logic [AW-1:0] wr_q;
  logic [AW-1:0] rd_q;
  logic [CW-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (clr_i) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= data_i;
        wr_q        <= wr_q + AW'(1);
      end
      if (pop_i) begin
        rd_q <= rd_q + AW'(1);
      end
      cnt_q <= cnt_q + CW'(push_i) - CW'(pop_i);
    end
  end

  assign data_o  = mem_q[rd_q];
  assign count_o = cnt_q;
  assign full_o  = (cnt_q == CW'(DEPTH));
  assign empty_o = (cnt_q == '0);

endmodule

// File: rtl/fetch.sv
// fetch: sequential-PC instruction fetch with credit-based buffering
// and redirect (nuke) handling in front of decode.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [63:0] RESET_PC        = FE_RESET_PC,
  parameter int          DEPTH           = FE_BUF_DEPTH,
  parameter int          MAX_OUTSTANDING = FE_MAX_OUTSTANDING
) (
  input  logic      clk,
  input  logic      reset_n,
  input  t_nuke_pkt nuke_rb1,
  fetch_if.master   fe_if
);

  localparam int CW = $clog2(MAX_OUTSTANDING) + 1;
  localparam int BW = $clog2(DEPTH) + 1;

  logic          run_q;
  logic [63:0]   pc_q, pc_d;
  logic [CW-1:0] out_q, out_d;
  logic [CW-1:0] drop_q, drop_d;

  logic          nuke, acc, rsp;
  logic          push, pop, credit;
  logic [BW-1:0] occ;
  logic          buf_full, buf_empty;
  logic [63:0]   rsp_pc;
  logic [CW-1:0] pcq_cnt;
  logic          pcq_full, pcq_empty;
  t_instr_pkt    push_pkt, head;

  assign nuke = nuke_rb1.valid;
  assign rsp  = fe_if.imem_rsp_valid;
  assign acc  = fe_if.imem_req_valid
              & fe_if.imem_req_ready;
  assign pop  = fe_if.valid_fe1
              & fe_if.decode_ready_de0;

  // Every in-flight request owns a buffer slot, so responses never stall.
  assign credit =
    (int'(occ) + int'(out_q) < DEPTH) &&
    (int'(out_q) < MAX_OUTSTANDING);

  assign fe_if.imem_req_valid = run_q & ~nuke & credit;
  assign fe_if.imem_req_addr  = pc_q;
  assign fe_if.valid_fe1      = ~buf_empty & ~nuke;
  assign fe_if.instr_fe1      = head;

  assign push = rsp & (drop_q == '0) & ~nuke;

  always_comb begin
    out_d  = out_q + CW'(acc) - CW'(rsp);
    pc_d   = pc_q;
    drop_d = drop_q;
    if (acc) begin
      pc_d = pc_q + 64'd4;
    end
    if (rsp && drop_q != '0) begin
      drop_d = drop_q - CW'(1);
    end
    // Reload, not accumulate: all still-pending requests are now stale.
    if (nuke) begin
      pc_d   = nuke_rb1.pc;
      drop_d = out_d;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      run_q  <= 1'b0;
      pc_q   <= RESET_PC;
      out_q  <= '0;
      drop_q <= '0;
    end else begin
      run_q  <= 1'b1;
      pc_q   <= pc_d;
      out_q  <= out_d;
      drop_q <= drop_d;
    end
  end

`ifdef SIMULATION
  logic [63:0] simid_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      simid_q <= '0;
    end else if (push) begin
      simid_q <= simid_q + 64'd1;
    end
  end
`endif

  always_comb begin
    push_pkt       = '0;
    push_pkt.instr = fe_if.imem_rsp_data;
    push_pkt.pc    = rsp_pc;
`ifdef SIMULATION
    push_pkt.SIMID = simid_q;
`endif
  end

  fetch_gen_fifo #(
    .T     (logic [63:0]),
    .DEPTH (MAX_OUTSTANDING)
  ) u_pcq (
    .clk     (clk),
    .rst_n   (reset_n),
    .clr_i   (1'b0),
    .push_i  (acc),
    .data_i  (pc_q),
    .pop_i   (rsp),
    .data_o  (rsp_pc),
    .count_o (pcq_cnt),
    .full_o  (pcq_full),
    .empty_o (pcq_empty)
  );

  fetch_gen_fifo #(
    .T     (t_instr_pkt),
    .DEPTH (DEPTH)
  ) u_buf (
    .clk     (clk),
    .rst_n   (reset_n),
    .clr_i   (nuke),
    .push_i  (push),
    .data_i  (push_pkt),
    .pop_i   (pop),
    .data_o  (head),
    .count_o (occ),
    .full_o  (buf_full),
    .empty_o (buf_empty)
  );

`ifndef SYNTHESIS
  a_nuke_align: assert property (
    @(posedge clk) disable iff (!reset_n)
    nuke |-> nuke_rb1.pc[1:0] == 2'b00);

  a_rsp_owed: assert property (
    @(posedge clk) disable iff (!reset_n)
    rsp |-> (out_q != '0) && !pcq_empty);

  a_buf_push: assert property (
    @(posedge clk) disable iff (!reset_n)
    (push && buf_full) |-> pop);

  a_pcq_sync: assert property (
    @(posedge clk) disable iff (!reset_n)
    (out_q == pcq_cnt) && !(acc && pcq_full));
`endif

endmodule
